// File: rtl/depth_test_pkg.sv
// +--------------------------------------------------------------------------+
// | depth_test_pkg : shared types and constants for the depth tester         |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

package depth_test_pkg;

  localparam int DEPTH_W  = 16;
  localparam int ADDR_W   = 16;
  localparam int PIPE_LAT = 4;
  localparam logic [DEPTH_W-1:0] FAR_DEPTH = 16'hFFFF;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic [10:0]        hcount;
    logic [9:0]         vcount;
    logic [DEPTH_W-1:0] depth;
    logic [31:0]        addr;
  } pixel_t;

endpackage

`default_nettype wire

// File: rtl/depth_buffer_ram.sv
// +--------------------------------------------------------------------------+
// | depth_buffer_ram : simple dual-port read-first RAM, 2-cycle read latency |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module depth_buffer_ram
  import depth_test_pkg::*;
#(
  parameter int DEPTH = 57600
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [DEPTH_W-1:0] wr_data,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [DEPTH_W-1:0] rd_data
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [DEPTH_W-1:0] mem [DEPTH];
  logic [DEPTH_W-1:0] rd_q;

  // Non-blocking read and write on the same edge give read-first behaviour.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr[IDX_W-1:0]] <= wr_data;
    end
    rd_q    <= mem[rd_addr[IDX_W-1:0]];
    rd_data <= rd_q;
  end

endmodule

`default_nettype wire

// File: rtl/depth_tester.sv
// +--------------------------------------------------------------------------+
// | depth_tester : z-buffer read-compare-write stage with write forwarding   |
// | Optional macro DEPTH_TEST_STATS_EN adds pass/reject counters.            |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module depth_tester
  import depth_test_pkg::*;
#(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 180
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [10:0]        hcount_in,
  input  logic [9:0]         vcount_in,
  input  logic [DEPTH_W-1:0] depth_in,
  input  logic [31:0]        addr_in,
  input  logic               data_valid_in,
  output logic               ready_out,
  input  logic               clear_in,
  output logic               clear_done_out,
  output logic [10:0]        hcount_out,
  output logic [9:0]         vcount_out,
  output logic [DEPTH_W-1:0] depth_out,
  output logic [31:0]        addr_out,
  output logic               data_valid_out
`ifdef DEPTH_TEST_STATS_EN
  ,
  output logic [31:0]        pass_count_out,
  output logic [31:0]        reject_count_out
`endif
);

  localparam int                NPIX      = WIDTH * HEIGHT;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
  localparam logic [10:0]       W_LIM     = 11'(WIDTH);
  localparam logic [9:0]        H_LIM     = 10'(HEIGHT);

  state_t              state, next_state;
  logic [ADDR_W-1:0]   sweep;

  logic [PIPE_LAT-2:0] stage_v;
  pixel_t              s1_pix, s2_pix, s3_pix;
  logic [ADDR_W-1:0]   s1_addr, s2_addr, s3_addr;

  logic                fwd0_v, fwd1_v;
  logic [ADDR_W-1:0]   fwd0_addr, fwd1_addr;
  logic [DEPTH_W-1:0]  fwd0_depth, fwd1_depth;

  logic [DEPTH_W-1:0]  ram_rd_data;
  logic [DEPTH_W-1:0]  stored;
  logic                accept, in_range, pass;
  logic [ADDR_W-1:0]   lin_addr;

  logic                ram_we;
  logic [ADDR_W-1:0]   ram_waddr;
  logic [DEPTH_W-1:0]  ram_wdata;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state <= CLEAR;
      sweep <= '0;
    end else begin
      state <= next_state;
      sweep <= (state == CLEAR && sweep != LAST_ADDR) ? sweep + 1'b1 : '0;
    end
  end

  always_comb begin
    next_state     = state;
    ready_out      = 1'b0;
    clear_done_out = 1'b0;
    case (state)
      CLEAR: begin
        if (sweep == LAST_ADDR) begin
          clear_done_out = 1'b1;
          next_state     = RUN;
        end
      end
      RUN: begin
        ready_out = !clear_in;
        if (clear_in) next_state = DRAIN;
      end
      DRAIN: begin
        if (stage_v == '0) next_state = CLEAR;
      end
      default: next_state = CLEAR;
    endcase
  end

  assign accept   = data_valid_in && ready_out;
  assign in_range = (hcount_in < W_LIM) && (vcount_in < H_LIM);
  assign lin_addr = ADDR_W'(vcount_in) * ADDR_W'(WIDTH) + ADDR_W'(hcount_in);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      stage_v <= '0;
      s1_pix  <= '0;
      s2_pix  <= '0;
      s3_pix  <= '0;
      s1_addr <= '0;
      s2_addr <= '0;
      s3_addr <= '0;
    end else begin
      stage_v <= {stage_v[PIPE_LAT-3:0], accept && in_range};
      s1_pix  <= {hcount_in, vcount_in, depth_in, addr_in};
      s1_addr <= lin_addr;
      s2_pix  <= s1_pix;
      s2_addr <= s1_addr;
      s3_pix  <= s2_pix;
      s3_addr <= s2_addr;
    end
  end

  // Writes from the previous two cycles are not yet visible in the RAM data.
  always_comb begin
    stored = ram_rd_data;
    if (fwd0_v && fwd0_addr == s3_addr) begin
      stored = fwd0_depth;
    end else if (fwd1_v && fwd1_addr == s3_addr) begin
      stored = fwd1_depth;
    end
  end

  assign pass = stage_v[PIPE_LAT-2] && (s3_pix.depth < stored);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      fwd0_v     <= 1'b0;
      fwd1_v     <= 1'b0;
      fwd0_addr  <= '0;
      fwd1_addr  <= '0;
      fwd0_depth <= '0;
      fwd1_depth <= '0;
    end else begin
      fwd0_v     <= pass;
      fwd0_addr  <= s3_addr;
      fwd0_depth <= s3_pix.depth;
      fwd1_v     <= fwd0_v;
      fwd1_addr  <= fwd0_addr;
      fwd1_depth <= fwd0_depth;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      data_valid_out <= 1'b0;
      hcount_out     <= '0;
      vcount_out     <= '0;
      depth_out      <= '0;
      addr_out       <= '0;
    end else begin
      data_valid_out <= pass;
      if (pass) begin
        hcount_out <= s3_pix.hcount;
        vcount_out <= s3_pix.vcount;
        depth_out  <= s3_pix.depth;
        addr_out   <= s3_pix.addr;
      end
    end
  end

  assign ram_we    = (state == CLEAR) || pass;
  assign ram_waddr = (state == CLEAR) ? sweep : s3_addr;
  assign ram_wdata = (state == CLEAR) ? FAR_DEPTH : s3_pix.depth;

  depth_buffer_ram #(
    .DEPTH (NPIX)
  ) u_ram (
    .clk     (clk_in),
    .wr_en   (ram_we),
    .wr_addr (ram_waddr),
    .wr_data (ram_wdata),
    .rd_addr (s1_addr),
    .rd_data (ram_rd_data)
  );

`ifdef DEPTH_TEST_STATS_EN
  // The pipeline is empty during CLEAR, so zeroing there equals zeroing on entry.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      pass_count_out   <= '0;
      reject_count_out <= '0;
    end else if (state == CLEAR) begin
      pass_count_out   <= '0;
      reject_count_out <= '0;
    end else begin
      if (pass && pass_count_out != '1) begin
        pass_count_out <= pass_count_out + 1'b1;
      end
      if (stage_v[PIPE_LAT-2] && !pass && reject_count_out != '1) begin
        reject_count_out <= reject_count_out + 1'b1;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_depth_tester.sv
// +--------------------------------------------------------------------------+
// | tb_depth_tester : scoreboard bench for depth_tester (64x36 screen)       |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_depth_tester;

  localparam int W    = 64;
  localparam int H    = 36;
  localparam int NPIX = W * H;

  typedef struct {
    logic [10:0] h;
    logic [9:0]  v;
    logic [15:0] d;
    logic [31:0] a;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] hcount_in = '0;
  logic [9:0]  vcount_in = '0;
  logic [15:0] depth_in = '0;
  logic [31:0] addr_in = '0;
  logic        data_valid_in = 1'b0;
  logic        clear_in = 1'b0;
  logic        ready_out, clear_done_out, data_valid_out;
  logic [10:0] hcount_out;
  logic [9:0]  vcount_out;
  logic [15:0] depth_out;
  logic [31:0] addr_out;
`ifdef DEPTH_TEST_STATS_EN
  logic [31:0] pass_count_out, reject_count_out;
`endif

  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   exp_pass = 0;
  int   exp_rej = 0;
  exp_t sb[$];
  exp_t e_mon;

  depth_tester #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk_in           (clk),
    .rst_in           (rst_n),
    .hcount_in        (hcount_in),
    .vcount_in        (vcount_in),
    .depth_in         (depth_in),
    .addr_in          (addr_in),
    .data_valid_in    (data_valid_in),
    .ready_out        (ready_out),
    .clear_in         (clear_in),
    .clear_done_out   (clear_done_out),
    .hcount_out       (hcount_out),
    .vcount_out       (vcount_out),
    .depth_out        (depth_out),
    .addr_out         (addr_out),
    .data_valid_out   (data_valid_out)
`ifdef DEPTH_TEST_STATS_EN
    ,
    .pass_count_out   (pass_count_out),
    .reject_count_out (reject_count_out)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // kind: 1 = passes, 0 = rejected by the depth test, 2 = never reaches the test
  task automatic drive(input int h, input int v, input int d, input int kind);
    exp_t e;
    hcount_in     = 11'(h);
    vcount_in     = 10'(v);
    depth_in      = 16'(d);
    addr_in       = 32'hA000_0000 + 32'(h * 1000 + v);
    data_valid_in = 1'b1;
    if (kind == 1) begin
      e.h = hcount_in; e.v = vcount_in; e.d = depth_in; e.a = addr_in;
      e.cyc = cyc + 4;
      sb.push_back(e);
      exp_pass++;
    end else if (kind == 0) begin
      exp_rej++;
    end
    @(posedge clk); #1;
    data_valid_in = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sb_empty(input string nm);
    idle(6);
    check(nm, 64'(sb.size()), 64'd0);
  endtask

  // Call at a negedge; counts ready-low cycles and clear_done pulses.
  task automatic wait_ready(input int lo, input int hi, input string nm);
    int low = 0;
    int dones = 0;
    while (!ready_out && low < 4 * NPIX) begin
      if (clear_done_out) dones++;
      low++;
      @(negedge clk);
    end
    n_checks++;
    if (low < lo || low > hi) begin
      n_fail++;
      $display("FAIL %s_ready_low: got %0d cycles, expected %0d..%0d", nm, low, lo, hi);
    end
    check({nm, "_done_pulses"}, 64'(dones), 64'd1);
    exp_pass = 0;
    exp_rej = 0;
  endtask

  task automatic check_stats(input string nm);
`ifdef DEPTH_TEST_STATS_EN
    check({nm, "_pass_count"}, 64'(pass_count_out), 64'(exp_pass));
    check({nm, "_reject_count"}, 64'(reject_count_out), 64'(exp_rej));
`else
    check({nm, "_sb_size"}, 64'(sb.size()), 64'd0);
`endif
  endtask

  always @(negedge clk) begin
    if (rst_n && data_valid_out) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 64'd1, 64'd0);
      end else begin
        e_mon = sb.pop_front();
        check("out_hcount", 64'(hcount_out), 64'(e_mon.h));
        check("out_vcount", 64'(vcount_out), 64'(e_mon.v));
        check("out_depth",  64'(depth_out),  64'(e_mon.d));
        check("out_addr",   64'(addr_out),   64'(e_mon.a));
        check("out_cycle",  64'(cyc),        64'(e_mon.cyc));
      end
    end
  end

  initial begin
    #(50000 * 10);
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    #1;
    check("rst_ready", 64'(ready_out), 64'd0);
    check("rst_outputs", {hcount_out, vcount_out, depth_out, addr_out[26:0], data_valid_out, clear_done_out}, 64'd0);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    wait_ready(NPIX, NPIX, "init_clear");
    check("init_outputs_zero", {hcount_out, vcount_out, depth_out, addr_out[26:0], data_valid_out}, 64'd0);

    // Single pixel: pass, farther rejected, nearer passes
    drive(10, 20, 16'h1000, 1); idle(6);
    drive(10, 20, 16'h2000, 0); idle(6);
    drive(10, 20, 16'h0FFF, 1);
    sb_empty("single_pixel_sb");

    // Back-to-back same address
    drive(5, 5, 16'h3000, 1);
    drive(5, 5, 16'h3000, 0);
    drive(5, 5, 16'h2FFF, 1);
    sb_empty("b2b_sb");

    // One apart, two apart, then four apart (plain RAM path)
    drive(7, 7, 16'h4000, 1);
    drive(8, 8, 16'h4000, 1);
    drive(7, 7, 16'h4000, 0);
    drive(8, 8, 16'h3FFF, 1);
    drive(7, 7, 16'h4000, 0);
    sb_empty("interleave_sb");

    // Most recent forward entry must win
    drive(9, 9, 16'h5000, 1);
    drive(9, 9, 16'h4FFF, 1);
    drive(9, 9, 16'h4FFF, 0);
    sb_empty("fwd_priority_sb");

    // Out of range: dropped, no write at aliased addresses
    drive(W, 0, 16'h0001, 2);
    drive(0, H, 16'h0001, 2);
    drive(0, 0, 16'h0001, 1);
    drive(0, 1, 16'h0002, 1);
    sb_empty("range_sb");
    check_stats("pre_clear");

    // clear_in with three pixels in flight; concurrent pixel is discarded
    drive(1, 1, 16'h0100, 1);
    drive(2, 2, 16'h0100, 1);
    drive(3, 3, 16'h0100, 1);
    clear_in = 1'b1;
    hcount_in = 11'd4; vcount_in = 10'd4; depth_in = 16'h0001; data_valid_in = 1'b1;
    @(negedge clk);
    check("clear_ready_drop", 64'(ready_out), 64'd0);
    @(posedge clk); #1;
    clear_in = 1'b0;
    data_valid_in = 1'b0;
    @(negedge clk);
    wait_ready(NPIX, NPIX + 9, "drain_clear");
    check("drain_sb", 64'(sb.size()), 64'd0);
    check_stats("post_clear");
    drive(10, 20, 16'hFFFE, 1);
    drive(4, 4, 16'hFFFF, 0);
    sb_empty("after_clear_sb");

    // Reset mid-RUN with a pixel in flight
    drive(11, 11, 16'h0010, 1);
    idle(5);
    check_stats("pre_reset");
    drive(12, 12, 16'h0010, 2);
    rst_n = 1'b0;
    #1;
    check("run_rst_outputs", {hcount_out, vcount_out, depth_out, addr_out[26:0], data_valid_out}, 64'd0);
    check("run_rst_ready", 64'(ready_out), 64'd0);
    exp_pass = 0;
    exp_rej = 0;
    check_stats("run_rst");
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    wait_ready(NPIX, NPIX, "run_rst_clear");

    // Reset mid-CLEAR restarts the full sweep
    drive(11, 11, 16'h0010, 1);
    sb_empty("pre_clear_rst_sb");
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    idle(100);
    rst_n = 1'b0;
    #1;
    check("clear_rst_outputs", {hcount_out, vcount_out, depth_out, addr_out[26:0], data_valid_out}, 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    wait_ready(NPIX, NPIX, "clear_rst_clear");
    check_stats("clear_rst");
    drive(11, 11, 16'h0010, 1);
    sb_empty("final_sb");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
